pixel_packer: RTL and testbench

//  Upstream stage of the MNIST classifier. Accepts a raster stream of 8-bit greyscale

---
 rtl/mnist_pkg.sv | 18 +
 rtl/pixel_packer_if.sv | 25 ++
 rtl/frame_buffer.sv | 35 +++
 rtl/pixel_packer.sv | 116 +++++++++++
 tb/tb_pixel_packer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST front end: image geometry, pixel/frame
// types and the packer FSM state encoding.
package mnist_pkg;

    localparam int IMG_DIM           = 28;
    localparam int NUM_PIXELS        = IMG_DIM * IMG_DIM;
    localparam int PIXEL_W           = 8;
    localparam int DEFAULT_THRESHOLD = 128;

    typedef logic [PIXEL_W-1:0]    pixel_t;
    typedef logic [NUM_PIXELS-1:0] frame_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/pixel_packer_if.sv
// Pixel-in / frame-out handshake bundle of the pixel packer.
// The master drives pixels and downstream ready; the slave is the packer itself.
interface pixel_packer_if #(
    parameter int PIXEL_W    = mnist_pkg::PIXEL_W,
    parameter int NUM_PIXELS = mnist_pkg::NUM_PIXELS
);
    logic                  valid_i;
    logic [PIXEL_W-1:0]    data_i;
    logic                  last_i;
    logic                  ready_o;
    logic                  valid_o;
    logic [NUM_PIXELS-1:0] data_o;
    logic                  ready_i;
    logic                  err_o;

    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, err_o
    );

    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, err_o
    );
endinterface

// File: rtl/frame_buffer.sv
// Single-entry valid/ready register slice for a packed frame. Accepts a new frame
// when empty or when the held frame is leaving on the same cycle.
module frame_buffer import mnist_pkg::*; #(
    parameter int WIDTH = NUM_PIXELS
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Thresholds a raster of greyscale pixels to one bit each and packs a whole frame
// into a wide vector; a filling frame and a pending output frame can coexist.
module pixel_packer #(
    parameter int PIXEL_W    = mnist_pkg::PIXEL_W,
    parameter int NUM_PIXELS = mnist_pkg::NUM_PIXELS,
    parameter int THRESHOLD  = mnist_pkg::DEFAULT_THRESHOLD
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    pixel_packer_if.slave  bus
);
    import mnist_pkg::*;

    localparam int                 COUNT_W  = $clog2(NUM_PIXELS);
    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(NUM_PIXELS - 1);
    localparam logic [PIXEL_W-1:0] THR      = PIXEL_W'(THRESHOLD);

    pack_state_t           state_reg, state_next;
    logic [COUNT_W-1:0]    count_reg, count_next;
    logic [NUM_PIXELS-1:0] fill_reg, fill_next, fill_merged;
    logic                  err_reg, err_next;

    logic                  load;
    logic [NUM_PIXELS-1:0] load_data;
    logic                  buf_free;
    logic                  ready;
    logic                  accept;
    logic                  pixel_bit;
    logic                  at_last;

    // ready depends only on registered state, never on valid_i.
    assign ready       = (state_reg == ST_FILL);
    assign bus.ready_o = ready;
    assign bus.err_o   = err_reg;
    assign accept      = bus.valid_i && ready;
    assign pixel_bit   = (bus.data_i >= THR);
    assign at_last     = (count_reg == LAST_IDX);

    always_comb begin
        fill_merged            = fill_reg;
        fill_merged[count_reg] = pixel_bit;
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        fill_next  = fill_reg;
        err_next   = 1'b0;
        load       = 1'b0;
        load_data  = fill_reg;
        case (state_reg)
            ST_FILL: begin
                if (accept) begin
                    if (at_last) begin
                        // A full frame completes even without last_i, but is flagged.
                        err_next = !bus.last_i;
                        if (buf_free) begin
                            load       = 1'b1;
                            load_data  = fill_merged;
                            count_next = '0;
                            fill_next  = '0;
                        end else begin
                            fill_next  = fill_merged;
                            state_next = ST_HOLD;
                        end
                    end else if (bus.last_i) begin
                        count_next = '0;
                        fill_next  = '0;
                        err_next   = 1'b1;
                    end else begin
                        fill_next  = fill_merged;
                        count_next = count_reg + COUNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (buf_free) begin
                    load       = 1'b1;
                    load_data  = fill_reg;
                    count_next = '0;
                    fill_next  = '0;
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg <= ST_FILL;
            count_reg <= '0;
            fill_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            fill_reg  <= fill_next;
            err_reg   <= err_next;
        end
    end

    frame_buffer #(
        .WIDTH (NUM_PIXELS)
    ) u_frame_buffer (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .in_valid  (load),
        .in_data   (load_data),
        .in_ready  (buf_free),
        .out_valid (bus.valid_o),
        .out_data  (bus.data_o),
        .out_ready (bus.ready_i)
    );

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: expected frames go to a scoreboard queue as they
// are driven and are compared when the packer hands them downstream.
`timescale 1ns/1ps
module tb_pixel_packer;
    import mnist_pkg::*;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;

    pixel_packer_if bus ();

    pixel_packer dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    int     pass_cnt    = 0;
    int     total_cnt   = 0;
    int     frames_seen = 0;
    int     err_pulses  = 0;
    frame_t exp_q[$];
    frame_t mon_exp;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_frame(string tag, frame_t obs, frame_t exp);
        int first_diff = 0;
        for (int k = NUM_PIXELS - 1; k >= 0; k--)
            if (obs[k] !== exp[k]) first_diff = k;
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: first differing bit %0d observed=%b expected=%b; low 64 bits observed=%h expected=%h",
                    tag, first_diff, obs[first_diff], exp[first_diff], obs[63:0], exp[63:0]);
    endtask

    // Downstream monitor: transfers and error pulses are sampled on the falling edge.
    always @(negedge clk_i) begin
        if (reset_ni === 1'b1) begin
            if (bus.err_o === 1'b1) err_pulses++;
            if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
                frames_seen++;
                chk("sb_has_entry", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    chk_frame("frame_data", bus.data_o, mon_exp);
                    $display("frame %0d transferred, low 32 bits %h", frames_seen, bus.data_o[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    function automatic pixel_t pix_of(int kind, int idx);
        case (kind)
            0:       return (idx % 2 == 0) ? 8'd200 : 8'd10;
            1:       return (idx == 0) ? 8'd127 : ((idx == 1) ? 8'd128 : 8'd0);
            3:       return (idx == 0) ? 8'd255 : 8'd0;
            default: return pixel_t'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Holds one pixel on the bus until the packer takes it; returns 1 ns after that edge.
    task automatic drive_pixel(pixel_t p, logic last);
        int waited = 0;
        bus.valid_i = 1'b1;
        bus.data_i  = p;
        bus.last_i  = last;
        while (bus.ready_o !== 1'b1 && waited < 50) begin
            tick(1);
            waited++;
        end
        if (bus.ready_o !== 1'b1) chk("accept_timeout", bus.ready_o, 1);
        tick(1);
    endtask

    task automatic send_frame(int kind, int n, int last_at, bit push);
        frame_t f = '0;
        for (int i = 0; i < n; i++) begin
            pixel_t p = pix_of(kind, i);
            f[i] = (p >= 8'd128);
            drive_pixel(p, i == last_at);
        end
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
        if (push) exp_q.push_back(f);
    endtask

    initial begin
        frame_t b;
        int     seen0;
        int     e0;

        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.last_i  = 1'b0;
        bus.ready_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid_o", bus.valid_o, 0);
        chk_frame("rst_data_o", bus.data_o, '0);
        chk("rst_err_o", bus.err_o, 0);
        chk("rst_ready_o", bus.ready_o, 1);
        reset_ni    = 1'b1;
        bus.ready_i = 1'b1;
        tick(1);

        // 1: alternating 200/10 frame, one-cycle latency
        send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1);
        chk("t1_latency_valid", bus.valid_o, 1);
        chk_frame("t1_pattern", bus.data_o, {392{2'b01}});
        tick(3);
        chk("t1_no_err", err_pulses, 0);
        chk("t1_ready", bus.ready_o, 1);

        // 2: threshold boundary 127 / 128
        send_frame(1, NUM_PIXELS, NUM_PIXELS - 1, 1);
        b    = '0;
        b[1] = 1'b1;
        chk_frame("t2_boundary", bus.data_o, b);
        tick(3);

        // 3: downstream stalled, two frames back-to-back
        bus.ready_i = 1'b0;
        send_frame(2, NUM_PIXELS, NUM_PIXELS - 1, 1);
        send_frame(2, NUM_PIXELS, NUM_PIXELS - 1, 1);
        chk("t3_ready_low", bus.ready_o, 0);
        chk("t3_valid_held", bus.valid_o, 1);
        tick(4);
        chk("t3_still_holding", bus.ready_o, 0);
        chk_frame("t3_data_stable", bus.data_o, exp_q[0]);
        seen0       = frames_seen;
        bus.ready_i = 1'b1;
        tick(1);
        chk("t3_first_out", frames_seen, seen0 + 1);
        chk("t3_ready_back", bus.ready_o, 1);
        chk("t3_valid_frame2", bus.valid_o, 1);
        tick(1);
        chk("t3_second_out", frames_seen, seen0 + 2);
        chk("t3_valid_drop", bus.valid_o, 0);
        tick(2);

        // 4: early last_i at count 99 discards the frame
        e0 = err_pulses;
        send_frame(2, 100, 99, 0);
        chk("t4_err_pulse", bus.err_o, 1);
        chk("t4_no_valid", bus.valid_o, 0);
        tick(1);
        chk("t4_err_cleared", bus.err_o, 0);
        chk("t4_err_count", err_pulses, e0 + 1);
        send_frame(2, NUM_PIXELS, NUM_PIXELS - 1, 1);
        tick(2);

        // 5: full frame with last_i never set
        e0 = err_pulses;
        send_frame(2, NUM_PIXELS, -1, 1);
        chk("t5_valid", bus.valid_o, 1);
        chk("t5_err_pulse", bus.err_o, 1);
        tick(2);
        chk("t5_err_count", err_pulses, e0 + 1);

        // 6: reset while a frame is pending and another is half filled
        bus.ready_i = 1'b0;
        send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1);
        send_frame(2, 400, -1, 0);
        chk("t6_valid_before", bus.valid_o, 1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("t6_rst_valid", bus.valid_o, 0);
        chk_frame("t6_rst_data", bus.data_o, '0);
        chk("t6_rst_ready", bus.ready_o, 1);
        exp_q.delete();
        tick(1);
        reset_ni    = 1'b1;
        bus.ready_i = 1'b1;
        tick(1);
        send_frame(3, NUM_PIXELS, NUM_PIXELS - 1, 1);
        chk_frame("t6_fresh_bit0", bus.data_o, frame_t'(1));
        tick(3);

        chk("sb_empty", exp_q.size(), 0);
        chk("frames_total", frames_seen, 7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
